// File: rtl/stream_demux.sv
// stream_demux: registered 1:NCH valid/ready demultiplexer with unicast/broadcast
// routing through a one-word output slot per channel.
module stream_demux #(
  parameter int NCH = 8,
  parameter int DW  = 8,
  localparam int SELW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DW-1:0]     s_data,
  input  logic [SELW-1:0]   s_sel,
  input  logic              s_bcast,
  output logic [NCH-1:0]    m_valid,
  input  logic [NCH-1:0]    m_ready,
  output logic [NCH*DW-1:0] m_data,
  output logic [7:0]        err_cnt
);

  logic [NCH-1:0]         m_valid_q, m_valid_d;
  logic [NCH-1:0][DW-1:0] m_data_q, m_data_d;
  logic [7:0]             err_cnt_q, err_cnt_d;
  logic [NCH-1:0]         can_acc, sel_hit, load;
  logic                   sel_oob, accept;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_comb begin
    can_acc = ~m_valid_q | m_ready;
    sel_hit = '0;
    for (int i = 0; i < NCH; i++) sel_hit[i] = (32'(s_sel) == i);
    sel_oob = (32'(s_sel) >= NCH);

    // Out-of-range unicasts are always taken so the producer never stalls on them.
    if (s_bcast)      s_ready = &can_acc;
    else if (sel_oob) s_ready = 1'b1;
    else              s_ready = |(can_acc & sel_hit);

    accept = s_valid & s_ready;
    load   = '0;
    if (s_bcast)       load = {NCH{accept}};
    else if (!sel_oob) load = sel_hit & {NCH{accept}};

    // A draining slot may be refilled in the same cycle.
    m_valid_d = (m_valid_q & ~m_ready) | load;
    m_data_d  = m_data_q;
    for (int i = 0; i < NCH; i++) begin
      if (load[i]) m_data_d[i] = s_data;
    end

    err_cnt_d = err_cnt_q;
    if (accept && !s_bcast && sel_oob) err_cnt_d = sat_inc8(err_cnt_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_q <= '0;
      m_data_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_stream_demux.sv
// Bench for stream_demux: directed cases on an 8-channel and a 5-channel instance,
// then random traffic against a queue-based reference model.
module tb_stream_demux;
  localparam int NCH  = 8;
  localparam int DW   = 8;
  localparam int NCH5 = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              s_valid, s_ready, s_bcast;
  logic [DW-1:0]     s_data;
  logic [2:0]        s_sel;
  logic [NCH-1:0]    m_valid, m_ready;
  logic [NCH*DW-1:0] m_data;
  logic [7:0]        err_cnt;

  logic               s5_valid, s5_ready, s5_bcast;
  logic [DW-1:0]      s5_data;
  logic [2:0]         s5_sel;
  logic [NCH5-1:0]    m5_valid, m5_ready;
  logic [NCH5*DW-1:0] m5_data;
  logic [7:0]         err5_cnt;

  stream_demux #(.NCH(NCH), .DW(DW)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_sel(s_sel), .s_bcast(s_bcast), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .err_cnt(err_cnt)
  );

  stream_demux #(.NCH(NCH5), .DW(DW)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .s_valid(s5_valid), .s_ready(s5_ready),
    .s_data(s5_data), .s_sel(s5_sel), .s_bcast(s5_bcast), .m_valid(m5_valid),
    .m_ready(m5_ready), .m_data(m5_data), .err_cnt(err5_cnt)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: words sitting in each channel's output slot, in order.
  logic [DW-1:0] q [NCH][$];

  initial begin
    int acc, cyc;
    logic exp_rdy;
    logic [NCH-1:0] exp_vld;

    s_valid = 0; s_bcast = 0; s_data = '0; s_sel = '0; m_ready = '0;
    s5_valid = 0; s5_bcast = 0; s5_data = '0; s5_sel = '0; m5_ready = '1;

    #12;
    check_eq("rst_m_valid", m_valid, 0);
    check_eq("rst_m_data", m_data, 0);
    check_eq("rst_err_cnt", err_cnt, 0);
    @(negedge clk); rst_n = 1'b1;
    tick();

    // T2 unicast
    m_ready = '1; s_valid = 1; s_sel = 3; s_data = 8'hA5; s_bcast = 0;
    #1 check_eq("t2_s_ready", s_ready, 1);
    tick(); s_valid = 0;
    check_eq("t2_m_valid", m_valid, 8'b0000_1000);
    check_eq("t2_m_data_ch3", m_data[31:24], 8'hA5);
    tick();
    check_eq("t2_drained", m_valid, 0);

    // T3 backpressure on ch3, then release without a gap
    m_ready = 8'hF7; s_valid = 1; s_sel = 3; s_data = 8'h11;
    tick();
    s_data = 8'h22;
    #1 check_eq("t3_s_ready_blocked", s_ready, 0);
    tick();
    check_eq("t3_held_valid", m_valid, 8'h08);
    check_eq("t3_held_data", m_data[31:24], 8'h11);
    m_ready = 8'hFF;
    #1 check_eq("t3_s_ready_release", s_ready, 1);
    tick(); s_valid = 0;
    check_eq("t3_refill_valid", m_valid, 8'h08);
    check_eq("t3_refill_data", m_data[31:24], 8'h22);
    tick();
    check_eq("t3_empty", m_valid, 0);

    // T4 broadcast blocked by stalled ch5
    m_ready = 8'hDF; s_valid = 1; s_sel = 5; s_data = 8'h55;
    tick();
    s_bcast = 1; s_data = 8'h3C;
    #1 check_eq("t4_s_ready_blocked", s_ready, 0);
    tick();
    check_eq("t4_no_change_valid", m_valid, 8'h20);
    check_eq("t4_no_change_data", m_data, 64'h0000_5500_2200_0000);
    m_ready = 8'hFF;
    #1 check_eq("t4_s_ready_release", s_ready, 1);
    tick(); s_valid = 0; s_bcast = 0;
    check_eq("t4_all_valid", m_valid, 8'hFF);
    check_eq("t4_all_data", m_data, 64'h3C3C_3C3C_3C3C_3C3C);
    tick();
    check_eq("t4_drained", m_valid, 0);

    // T5 out-of-range select on the 5-channel instance
    s5_valid = 1; s5_sel = 4; s5_data = 8'h77;
    tick();
    check_eq("t5_unicast_valid", m5_valid, 5'h10);
    check_eq("t5_unicast_data", m5_data[39:32], 8'h77);
    s5_sel = 6;
    for (int k = 1; k <= 300; k++) begin
      #1 check_eq("t5_s_ready", s5_ready, 1);
      tick();
      check_eq("t5_m_valid", m5_valid, 0);
      check_eq("t5_err_cnt", err5_cnt, (k > 255) ? 255 : k);
    end
    s5_valid = 0;
    tick();
    check_eq("t5_err_hold", err5_cnt, 255);

    // T1 reset asserted mid-traffic, between clock edges
    m_ready = '0; s_valid = 1; s_sel = 2; s_data = 8'h99;
    tick();
    check_eq("t1_pre_valid", m_valid, 8'h04);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t1_async_valid", m_valid, 0);
    check_eq("t1_async_data", m_data, 0);
    check_eq("t1_async_err5", err5_cnt, 0);
    tick();
    check_eq("t1_held_valid", m_valid, 0);
    s_valid = 0;
    @(negedge clk); rst_n = 1'b1;
    #1 check_eq("t1_release_valid", m_valid, 0);
    tick();

    // T6 random traffic against the queue model
    acc = 0; cyc = 0;
    while (acc < 10000 && cyc < 40000) begin
      s_valid = ($urandom_range(0, 3) != 0);
      s_bcast = ($urandom_range(0, 7) == 0);
      s_sel   = 3'($urandom);
      s_data  = 8'($urandom);
      for (int i = 0; i < NCH; i++) m_ready[i] = ($urandom_range(0, 3) != 0);
      #1;
      if (s_bcast) begin
        exp_rdy = 1'b1;
        for (int i = 0; i < NCH; i++)
          if (q[i].size() != 0 && !m_ready[i]) exp_rdy = 1'b0;
      end else begin
        exp_rdy = (q[s_sel].size() == 0) || m_ready[s_sel];
      end
      check_eq("t6_s_ready", s_ready, exp_rdy);
      for (int i = 0; i < NCH; i++) exp_vld[i] = (q[i].size() != 0);
      check_eq("t6_m_valid", m_valid, exp_vld);
      for (int i = 0; i < NCH; i++) begin
        if (q[i].size() != 0) check_eq("t6_m_data", m_data[i*DW +: DW], q[i][0]);
        if (q[i].size() != 0 && m_ready[i]) void'(q[i].pop_front());
      end
      if (s_valid && exp_rdy) begin
        acc++;
        if (s_bcast) for (int i = 0; i < NCH; i++) q[i].push_back(s_data);
        else q[s_sel].push_back(s_data);
      end
      tick();
      cyc++;
    end
    check_eq("t6_words_done", (acc >= 10000), 1);
    check_eq("t6_err_cnt", err_cnt, 0);
    s_valid = 0;
    m_ready = '1;
    for (int i = 0; i < NCH; i++) exp_vld[i] = (q[i].size() != 0);
    #1 check_eq("t6_final_valid", m_valid, exp_vld);
    tick();
    check_eq("t6_final_drain", m_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
